// File: rtl/game_event_if.sv
// Event bus between the Tetris flow controller (master) and the playfield/register file (slave).
// GAME_EVT_HARD_DROP_EN adds the btn_drop input.
interface game_event_if #(
    parameter int ROWS = 20,
    parameter int Y_W  = 5
);
    logic            gravity_tick;
    logic            btn_rotate;
    logic            btn_restart;
    logic            landed;
    logic [ROWS-1:0] full_rows;
    logic [31:0]     shape_in;
`ifdef GAME_EVT_HARD_DROP_EN
    logic            btn_drop;
`endif
    logic            change_shape;
    logic            stop;
    logic            clear;
    logic [Y_W-1:0]  row_clear_idx;
    logic            start_over;
    logic [Y_W-1:0]  piece_y;
    logic            game_over;

    modport master (
`ifdef GAME_EVT_HARD_DROP_EN
        input  btn_drop,
`endif
        input  gravity_tick, btn_rotate, btn_restart, landed, full_rows, shape_in,
        output change_shape, stop, clear, row_clear_idx, start_over, piece_y, game_over
    );

    modport slave (
`ifdef GAME_EVT_HARD_DROP_EN
        output btn_drop,
`endif
        output gravity_tick, btn_rotate, btn_restart, landed, full_rows, shape_in,
        input  change_shape, stop, clear, row_clear_idx, start_over, piece_y, game_over
    );
endinterface

// File: rtl/game_event_ctrl.sv
// Tetris game-flow controller: spawn / fall / lock / line-clear / game-over event sequencing.
// GAME_EVT_HARD_DROP_EN enables the btn_drop fast-fall mode.
//
// state | meaning
// SPAWN | new piece enters, piece_y reset; blocked spawn ends the game
// FALL  | piece descends on gravity ticks (or every cycle in fast mode)
// LOCK  | piece fixed; snapshot of full rows taken
// CLEAR | one clear pulse per snapshotted row, highest row first
// OVER  | game over; only a restart leaves
module game_event_ctrl #(
    parameter int ROWS      = 20,
    parameter int Y_W       = 5,
    parameter int CLEAR_GAP = 2
) (
    input logic clock,
    input logic resetn,
    game_event_if.master evt
);
    typedef enum logic [2:0] {SPAWN, FALL, LOCK, CLEAR, OVER} state_t;

    localparam logic [Y_W-1:0] Y_MAX    = Y_W'(ROWS - 1);
    localparam logic [3:0]     GAP_INIT = 4'(CLEAR_GAP);

    state_t          state_q, state_d;
    logic            rot_prev_q, restart_prev_q;
    logic            rot_edge, restart_edge, drop_edge;
    logic            fast_q, fast_d, fast_act, lock_req;
    logic [ROWS-1:0] mask_q, mask_d, find_src, find_rest;
    logic [Y_W-1:0]  find_idx;
    logic [3:0]      gap_q, gap_d;
    logic [Y_W-1:0]  piece_y_q, piece_y_d, row_idx_q, row_idx_d;
    logic            change_q, change_d, stop_q, stop_d, clear_q, clear_d;
    logic            start_q, start_d, over_q, over_d;

    assign rot_edge     = evt.btn_rotate & ~rot_prev_q;
    assign restart_edge = evt.btn_restart & ~restart_prev_q;

`ifdef GAME_EVT_HARD_DROP_EN
    logic drop_prev_q;
    assign drop_edge = evt.btn_drop & ~drop_prev_q;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) drop_prev_q <= 1'b0;
        else         drop_prev_q <= evt.btn_drop;
    end
`else
    assign drop_edge = 1'b0;
`endif

    // A drop edge counts as fast mode already in its own cycle
    assign fast_act = (state_q == FALL) && (fast_q || drop_edge);
    assign lock_req = (state_q == FALL) && evt.landed && (fast_act || evt.gravity_tick);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q        <= SPAWN;
            rot_prev_q     <= 1'b0;
            restart_prev_q <= 1'b0;
            fast_q         <= 1'b0;
            mask_q         <= '0;
            gap_q          <= '0;
            piece_y_q      <= '0;
            row_idx_q      <= '0;
            change_q       <= 1'b0;
            stop_q         <= 1'b0;
            clear_q        <= 1'b0;
            start_q        <= 1'b0;
            over_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rot_prev_q     <= evt.btn_rotate;
            restart_prev_q <= evt.btn_restart;
            fast_q         <= fast_d;
            mask_q         <= mask_d;
            gap_q          <= gap_d;
            piece_y_q      <= piece_y_d;
            row_idx_q      <= row_idx_d;
            change_q       <= change_d;
            stop_q         <= stop_d;
            clear_q        <= clear_d;
            start_q        <= start_d;
            over_q         <= over_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (restart_edge) begin
            state_d = SPAWN;
        end else begin
            case (state_q)
                SPAWN:   state_d = evt.landed ? OVER : FALL;
                FALL:    if (lock_req) state_d = LOCK;
                LOCK:    state_d = (evt.full_rows == '0) ? SPAWN : CLEAR;
                CLEAR:   if (gap_q == '0 && mask_q == '0) state_d = SPAWN;
                OVER:    state_d = OVER;
                default: state_d = SPAWN;
            endcase
        end
    end

    // Highest set row of the snapshot (or of the live mask), plus the mask without it
    always_comb begin
        find_src = (state_q == LOCK) ? evt.full_rows : mask_q;
        find_idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (find_src[i]) find_idx = Y_W'(i);
        end
        for (int i = 0; i < ROWS; i++) begin
            find_rest[i] = find_src[i] && (Y_W'(i) != find_idx);
        end
    end

    always_comb begin
        piece_y_d = piece_y_q;
        mask_d    = mask_q;
        gap_d     = gap_q;
        fast_d    = fast_q;
        row_idx_d = row_idx_q;
        change_d  = 1'b0;
        stop_d    = 1'b0;
        clear_d   = 1'b0;
        start_d   = 1'b0;
        over_d    = (state_d == OVER);
        if (restart_edge) begin
            start_d   = 1'b1;
            piece_y_d = '0;
            mask_d    = '0;
            gap_d     = '0;
            fast_d    = 1'b0;
        end else begin
            case (state_q)
                SPAWN: begin
                    piece_y_d = '0;
                    fast_d    = 1'b0;
                end
                FALL: begin
                    if (lock_req) begin
                        stop_d = 1'b1;
                        fast_d = 1'b0;
                    end else begin
                        fast_d = fast_act;
                        if ((fast_act || evt.gravity_tick) && piece_y_q != Y_MAX)
                            piece_y_d = piece_y_q + Y_W'(1);
                        if (rot_edge && !fast_act && evt.shape_in < 32'd14)
                            change_d = 1'b1;
                    end
                end
                LOCK: begin
                    mask_d = '0;
                    if (find_src != '0) begin
                        clear_d   = 1'b1;
                        row_idx_d = find_idx;
                        mask_d    = find_rest;
                        gap_d     = GAP_INIT;
                    end
                end
                CLEAR: begin
                    if (gap_q != '0) begin
                        gap_d = gap_q - 4'd1;
                    end else if (mask_q != '0) begin
                        clear_d   = 1'b1;
                        row_idx_d = find_idx;
                        mask_d    = find_rest;
                        gap_d     = GAP_INIT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign evt.change_shape  = change_q;
    assign evt.stop          = stop_q;
    assign evt.clear         = clear_q;
    assign evt.row_clear_idx = row_idx_q;
    assign evt.start_over    = start_q;
    assign evt.piece_y       = piece_y_q;
    assign evt.game_over     = over_q;
endmodule

// File: tb/tb_game_event_ctrl.sv
// Self-checking bench for game_event_ctrl: vector table through a scoreboard queue,
// plus hand-written reset-mid-clear and (with GAME_EVT_HARD_DROP_EN) hard-drop sequences.
module tb_game_event_ctrl;
    typedef struct {
        logic        tick, rot, rst, landed;
        logic [19:0] full;
        logic [31:0] shape;
        logic [14:0] exp;
    } vec_t;

    logic clock;
    logic resetn;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs[$];
    logic [14:0] sb[$];

    game_event_if #(.ROWS(20), .Y_W(5)) bus ();

    game_event_ctrl #(.ROWS(20), .Y_W(5), .CLEAR_GAP(2)) dut (
        .clock (clock),
        .resetn(resetn),
        .evt   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [14:0] ew(input logic chg, stp, clr, input logic [4:0] idx,
                                       input logic so, input logic [4:0] py, input logic go);
        return {chg, stp, clr, (clr ? idx : 5'd0), so, py, go};
    endfunction

    function automatic logic [14:0] dut_word();
        return ew(bus.change_shape, bus.stop, bus.clear, bus.row_clear_idx,
                  bus.start_over, bus.piece_y, bus.game_over);
    endfunction

    function automatic vec_t mk(input logic tick, rot, rst, landed, input logic [19:0] full,
                                input logic [31:0] shape, input logic [14:0] exp);
        vec_t v;
        v.tick = tick; v.rot = rot; v.rst = rst; v.landed = landed;
        v.full = full; v.shape = shape; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic tick, rot, rst, landed, input logic [19:0] full,
                         input logic [31:0] shape);
        bus.gravity_tick = tick;
        bus.btn_rotate   = rot;
        bus.btn_restart  = rst;
        bus.landed       = landed;
        bus.full_rows    = full;
        bus.shape_in     = shape;
    endtask

    initial begin
        int clr_cnt;
        logic [14:0] z;
        z = ew(0, 0, 0, 0, 0, 0, 0);

        // reset -> spawn/fall, 3 ticks, lock with no full rows
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, z));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, ew(0, 0, 0, 0, 0, 1, 0)));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, ew(0, 0, 0, 0, 0, 2, 0)));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, ew(0, 0, 0, 0, 0, 3, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, ew(0, 0, 0, 0, 0, 3, 0)));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, ew(0, 1, 0, 0, 0, 3, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, ew(0, 0, 0, 0, 0, 3, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, z));
        // rotation: valid shape, held button, invalid shape 14, boundary 13
        vecs.push_back(mk(0, 1, 0, 0, 0, 5, ew(1, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 1, 0, 0, 0, 5, z));
        vecs.push_back(mk(0, 0, 0, 0, 0, 5, z));
        vecs.push_back(mk(0, 1, 0, 0, 0, 14, z));
        vecs.push_back(mk(0, 0, 0, 0, 0, 14, z));
        vecs.push_back(mk(0, 1, 0, 0, 0, 13, ew(1, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 13, z));
        // rotate edge together with a locking tick: rotation dropped
        vecs.push_back(mk(1, 1, 0, 1, 0, 5, ew(0, 1, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 5, z));
        vecs.push_back(mk(0, 0, 0, 0, 0, 5, z));
        // lock with rows 0 and 2 full: clears idx 2 then idx 0, three cycles apart
        vecs.push_back(mk(1, 0, 0, 1, 20'h5, 0, ew(0, 1, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 20'h5, 0, ew(0, 0, 1, 2, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, z));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, z));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, ew(0, 0, 1, 0, 0, 0, 0)));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, z));
        // blocked spawn -> game over; ticks/rotates ignored; restart
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, ew(0, 1, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, z));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, ew(0, 0, 0, 0, 0, 0, 1)));
        vecs.push_back(mk(1, 1, 0, 0, 0, 5, ew(0, 0, 0, 0, 0, 0, 1)));
        vecs.push_back(mk(1, 0, 0, 0, 0, 5, ew(0, 0, 0, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, ew(0, 0, 0, 0, 1, 0, 0)));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, z));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, z));
        // piece_y saturates at ROWS-1
        for (int i = 0; i < 21; i++)
            vecs.push_back(mk(1, 0, 0, 0, 0, 0, ew(0, 0, 0, 0, 0, 5'((i + 1 > 19) ? 19 : i + 1), 0)));
        // restart mid-clear with three rows pending
        vecs.push_back(mk(1, 0, 0, 1, 20'h7, 0, ew(0, 1, 0, 0, 0, 19, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 20'h7, 0, ew(0, 0, 1, 2, 0, 19, 0)));
        vecs.push_back(mk(0, 0, 1, 0, 20'h7, 0, ew(0, 0, 0, 0, 1, 0, 0)));
        for (int i = 0; i < 7; i++) vecs.push_back(mk(0, 0, 0, 0, 20'h7, 0, z));

        resetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
`ifdef GAME_EVT_HARD_DROP_EN
        bus.btn_drop = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", 32'(dut_word()), 32'(z));
        check("reset_row_idx", 32'(bus.row_clear_idx), 0);
        @(negedge clock);
        resetn = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].tick, vecs[k].rot, vecs[k].rst, vecs[k].landed, vecs[k].full, vecs[k].shape);
            sb.push_back(vecs[k].exp);
            step();
            if (sb.size() == 0) begin
                check("scoreboard_empty", 1, 0);
            end else begin
                logic [14:0] e;
                e = sb.pop_front();
                check($sformatf("vec%0d", k), 32'(dut_word()), 32'(e));
            end
        end

        // resetn asserted mid-clear: outputs drop at once, remaining clears abandoned
        drive(1, 0, 0, 1, 20'h7, 0);
        step();
        check("rst_mid_stop", 32'(dut_word()), 32'(ew(0, 1, 0, 0, 0, 0, 0)));
        drive(0, 0, 0, 0, 20'h7, 0);
        step();
        check("rst_mid_clear", 32'(dut_word()), 32'(ew(0, 0, 1, 2, 0, 0, 0)));
        #2 resetn = 1'b0;
        #1;
        check("rst_mid_async", 32'(dut_word()), 32'(z));
        check("rst_mid_idx", 32'(bus.row_clear_idx), 0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        clr_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.clear) clr_cnt++;
        end
        check("rst_mid_no_more_clears", clr_cnt, 0);
        drive(0, 0, 0, 0, 0, 0);

`ifdef GAME_EVT_HARD_DROP_EN
        // hard drop from piece_y=1, landed once piece_y reaches 6
        drive(1, 0, 0, 0, 0, 0);
        step();
        check("drop_start_y", 32'(bus.piece_y), 1);
        bus.gravity_tick = 1'b0;
        bus.btn_drop = 1'b1;
        for (int y = 2; y <= 6; y++) begin
            step();
            check($sformatf("drop_y%0d", y), 32'(dut_word()), 32'(ew(0, 0, 0, 0, 0, 5'(y), 0)));
        end
        bus.landed = 1'b1;
        step();
        check("drop_stop", 32'(dut_word()), 32'(ew(0, 1, 0, 0, 0, 6, 0)));
        bus.landed = 1'b0;
        bus.btn_drop = 1'b0;
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
